// File: rtl/touch_pkg.sv
// -----------------------------------------------------------------------------
// touch_pkg
// Shared definitions for the touch Avalon-MM register front end:
//   - Avalon word addresses of the STATUS, CTRL and first POINT registers
//   - bit positions inside STATUS and CTRL
//   - LCD ID codes (lcd_id[15:8]) that select the resistive XPT2046 path
//   - 32-bit point word type {x[15:0], y[15:0]} and the front-end FSM states
// -----------------------------------------------------------------------------
package touch_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_CTRL   = 4'd1;
    localparam logic [3:0] ADDR_POINT0 = 4'd2;

    localparam int ST_NUM_LSB   = 0;
    localparam int ST_TOUCH_BIT = 3;
    localparam int ST_NEW_BIT   = 4;
    localparam int ST_SEQ_LSB   = 8;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;

    localparam logic [7:0] LCD_ID_XPT_0 = 8'h93;
    localparam logic [7:0] LCD_ID_XPT_1 = 8'h53;

    typedef logic [31:0] point_t;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Panels with these ID high bytes carry the resistive (single point) controller.
    function automatic logic is_src_a(input logic [7:0] id_hi);
        return (id_hi == LCD_ID_XPT_0) || (id_hi == LCD_ID_XPT_1);
    endfunction

endpackage

// File: rtl/touch_src_mux.sv
// -----------------------------------------------------------------------------
// touch_src_mux
// Picks the active touch controller from the LCD ID and presents one unified
// report bundle to the register block.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   lcd_id_hi_i         lcd_id[15:8]
//   xpt_*_i             resistive source: done pulse, valid, single point
//   gt_*_i              capacitive source: done pulse, valid, count, points
//   src_chg_o           1 for one cycle whenever lcd_id[15:8] changes
//   done_o, valid_o     selected source report strobe / touch-present flag
//   num_o               point count, clamped to TP_MAX
//   pts_o               TP_MAX point words; slots >= num_o are forced to 0
// -----------------------------------------------------------------------------
module touch_src_mux
    import touch_pkg::*;
#(
    parameter int TP_MAX = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            lcd_id_hi_i,
    input  logic                  xpt_done_i,
    input  logic                  xpt_valid_i,
    input  logic [31:0]           xpt_xy_i,
    input  logic                  gt_done_i,
    input  logic                  gt_valid_i,
    input  logic [2:0]            gt_num_i,
    input  logic [32*TP_MAX-1:0]  gt_xy_i,
    output logic                  src_chg_o,
    output logic                  done_o,
    output logic                  valid_o,
    output logic [2:0]            num_o,
    output logic [32*TP_MAX-1:0]  pts_o
);

    localparam logic [2:0] TP_MAX_N = 3'(TP_MAX);

    logic [7:0] id_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q <= 8'd0;
        end else begin
            id_q <= lcd_id_hi_i;
        end
    end

    assign src_chg_o = (lcd_id_hi_i != id_q);

    always_comb begin
        done_o  = 1'b0;
        valid_o = 1'b0;
        num_o   = 3'd0;
        pts_o   = '0;
        if (is_src_a(lcd_id_hi_i)) begin
            done_o       = xpt_done_i;
            valid_o      = xpt_valid_i;
            num_o        = 3'd1;
            pts_o[31:0]  = xpt_xy_i;
        end else begin
            done_o  = gt_done_i;
            valid_o = gt_valid_i;
            num_o   = (gt_num_i > TP_MAX_N) ? TP_MAX_N : gt_num_i;
            // Stale slots beyond the reported count must read back as 0.
            for (int k = 0; k < TP_MAX; k++) begin
                if (3'(k) < num_o) begin
                    pts_o[32*k +: 32] = gt_xy_i[32*k +: 32];
                end
            end
        end
    end

endmodule

// File: rtl/touch_avl_regs.sv
// -----------------------------------------------------------------------------
// touch_avl_regs
// Avalon-MM register front end for the touch subsystem. Captures touch reports
// from the selected controller into a live bank, hands software a coherent
// snapshot on each STATUS read, and tracks new-data, sequence and release.
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   lcd_init_done         capture inhibited while low
//   lcd_id                [15:8] selects resistive (0x93/0x53) or capacitive
//   xpt_* / gt_*          controller report inputs
//   avl_*                 Avalon-MM slave, 4-bit word address, read latency 1
//   irq                   level interrupt (irq_en & new), only when the
//                         TOUCH_IRQ_EN macro is defined
// Registers: 0 STATUS {seq, new, touching, num}, 1 CTRL {irq_en, enable},
//            2..TP_MAX+1 snapshot points.
// -----------------------------------------------------------------------------
module touch_avl_regs
    import touch_pkg::*;
#(
    parameter int TP_MAX      = 5,
    parameter int RELEASE_CYC = 2500000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  lcd_init_done,
    input  logic [15:0]           lcd_id,
    input  logic                  xpt_done,
    input  logic                  xpt_valid,
    input  logic [31:0]           xpt_xy,
    input  logic                  gt_done,
    input  logic                  gt_valid,
    input  logic [2:0]            gt_num,
    input  logic [32*TP_MAX-1:0]  gt_xy,
    input  logic [3:0]            avl_address,
    input  logic                  avl_write,
    input  logic                  avl_read,
    input  logic [31:0]           avl_writedata,
    output logic [31:0]           avl_readdata
`ifdef TOUCH_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int CNT_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RELEASE_CYC - 1);

    logic                  src_chg;
    logic                  m_done;
    logic                  m_valid;
    logic [2:0]            m_num;
    logic [32*TP_MAX-1:0]  m_pts;

    touch_src_mux #(.TP_MAX(TP_MAX)) u_src_mux (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .lcd_id_hi_i (lcd_id[15:8]),
        .xpt_done_i  (xpt_done),
        .xpt_valid_i (xpt_valid),
        .xpt_xy_i    (xpt_xy),
        .gt_done_i   (gt_done),
        .gt_valid_i  (gt_valid),
        .gt_num_i    (gt_num),
        .gt_xy_i     (gt_xy),
        .src_chg_o   (src_chg),
        .done_o      (m_done),
        .valid_o     (m_valid),
        .num_o       (m_num),
        .pts_o       (m_pts)
    );

    state_t            state_q;
    logic              enable_q;
    logic [7:0]        seq_q;
    logic              new_q;
    logic [2:0]        live_num_q;
    point_t            live_pts_q [TP_MAX];
    point_t            snap_pts_q [TP_MAX];
    logic [CNT_W-1:0]  rel_cnt_q;
    logic [31:0]       rdata_q;
`ifdef TOUCH_IRQ_EN
    logic              irq_en_q;
    logic              irq_q;
`endif

    logic              go_off;
    logic              cap;
    logic              rel;
    logic              rd_status;
    logic              new_d;
    logic [7:0]        seq_d;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    // Any inhibit (LCD not ready, disabled, panel swap) parks the FSM in OFF.
    assign go_off    = !lcd_init_done || !enable_q || src_chg;
    assign cap       = !go_off && (state_q != ST_OFF) && m_done && m_valid;
    assign rel       = !go_off && (state_q == ST_ACTIVE) && !cap &&
                       ((m_done && !m_valid) || (rel_cnt_q == '0));
    assign rd_status = avl_read && (avl_address == ADDR_STATUS);
    // A capture/release in the same cycle as the clearing read wins.
    assign new_d     = (cap || rel) ? 1'b1 : (rd_status ? 1'b0 : new_q);
    assign seq_d     = seq_q + {7'd0, (cap || rel)};

    always_comb begin
        status_word                     = '0;
        status_word[ST_SEQ_LSB +: 8]    = seq_q;
        status_word[ST_NEW_BIT]         = new_q;
        status_word[ST_TOUCH_BIT]       = (state_q == ST_ACTIVE);
        status_word[ST_NUM_LSB +: 3]    = live_num_q;
    end

    always_comb begin
        rd_mux = '0;
        if (avl_address == ADDR_STATUS) begin
            rd_mux = status_word;
        end else if (avl_address == ADDR_CTRL) begin
            rd_mux[CTRL_EN_BIT] = enable_q;
`ifdef TOUCH_IRQ_EN
            rd_mux[CTRL_IRQ_BIT] = irq_en_q;
`else
            rd_mux[CTRL_IRQ_BIT] = 1'b0;
`endif
        end else begin
            for (int k = 0; k < TP_MAX; k++) begin
                if (avl_address == (ADDR_POINT0 + 4'(k))) begin
                    rd_mux = snap_pts_q[k];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_OFF;
            enable_q   <= 1'b1;
            seq_q      <= 8'd0;
            new_q      <= 1'b0;
            live_num_q <= 3'd0;
            rel_cnt_q  <= '0;
            rdata_q    <= 32'd0;
            for (int k = 0; k < TP_MAX; k++) begin
                live_pts_q[k] <= '0;
                snap_pts_q[k] <= '0;
            end
`ifdef TOUCH_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            seq_q <= seq_d;
            new_q <= new_d;
`ifdef TOUCH_IRQ_EN
            irq_q <= irq_en_q & new_d;
`endif
            if (avl_read) begin
                rdata_q <= rd_mux;
            end
            if (avl_write && (avl_address == ADDR_CTRL)) begin
                enable_q <= avl_writedata[CTRL_EN_BIT];
`ifdef TOUCH_IRQ_EN
                irq_en_q <= avl_writedata[CTRL_IRQ_BIT];
`endif
            end

            // Snapshot copies pre-update live values, so a same-cycle capture
            // is only seen by the following STATUS read.
            if (src_chg) begin
                for (int k = 0; k < TP_MAX; k++) snap_pts_q[k] <= '0;
            end else if (rd_status) begin
                for (int k = 0; k < TP_MAX; k++) snap_pts_q[k] <= live_pts_q[k];
            end

            if (go_off) begin
                state_q    <= ST_OFF;
                live_num_q <= 3'd0;
                for (int k = 0; k < TP_MAX; k++) live_pts_q[k] <= '0;
            end else begin
                case (state_q)
                    ST_OFF: state_q <= ST_IDLE;
                    ST_IDLE, ST_ACTIVE: begin
                        if (cap) begin
                            state_q    <= ST_ACTIVE;
                            live_num_q <= m_num;
                            rel_cnt_q  <= CNT_RELOAD;
                            for (int k = 0; k < TP_MAX; k++) begin
                                live_pts_q[k] <= m_pts[32*k +: 32];
                            end
                        end else if (rel) begin
                            state_q    <= ST_IDLE;
                            live_num_q <= 3'd0;
                            for (int k = 0; k < TP_MAX; k++) live_pts_q[k] <= '0;
                        end else if (state_q == ST_ACTIVE) begin
                            rel_cnt_q <= rel_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_OFF;
                endcase
            end
        end
    end

    assign avl_readdata = rdata_q;

`ifdef TOUCH_IRQ_EN
    assign irq         = irq_q;
    assign unused_bits = ^{lcd_id[7:0], avl_writedata[31:2]};
`else
    assign unused_bits = ^{lcd_id[7:0], avl_writedata[31:1]};
`endif

endmodule

// File: tb/tb_touch_avl_regs.sv
module tb_touch_avl_regs;

    localparam int TP_MAX      = 5;
    localparam int RELEASE_CYC = 10;

    localparam logic [31:0] P0 = 32'h0001_0002;
    localparam logic [31:0] P1 = 32'h0003_0004;
    localparam logic [31:0] P2 = 32'h0005_0006;
    localparam logic [31:0] P3 = 32'h0007_0008;
    localparam logic [31:0] P4 = 32'h0009_000A;

    logic                  sys_clk;
    logic                  sys_rst;
    logic                  lcd_init_done;
    logic [15:0]           lcd_id;
    logic                  xpt_done;
    logic                  xpt_valid;
    logic [31:0]           xpt_xy;
    logic                  gt_done;
    logic                  gt_valid;
    logic [2:0]            gt_num;
    logic [32*TP_MAX-1:0]  gt_xy;
    logic [3:0]            avl_address;
    logic                  avl_write;
    logic                  avl_read;
    logic [31:0]           avl_writedata;
    logic [31:0]           avl_readdata;
`ifdef TOUCH_IRQ_EN
    logic                  irq;
`endif

    touch_avl_regs #(.TP_MAX(TP_MAX), .RELEASE_CYC(RELEASE_CYC)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .lcd_init_done (lcd_init_done),
        .lcd_id        (lcd_id),
        .xpt_done      (xpt_done),
        .xpt_valid     (xpt_valid),
        .xpt_xy        (xpt_xy),
        .gt_done       (gt_done),
        .gt_valid      (gt_valid),
        .gt_num        (gt_num),
        .gt_xy         (gt_xy),
        .avl_address   (avl_address),
        .avl_write     (avl_write),
        .avl_read      (avl_read),
        .avl_writedata (avl_writedata),
        .avl_readdata  (avl_readdata)
`ifdef TOUCH_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        mon_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every read strobe seen at a clock edge pops one expectation.
    always @(posedge sys_clk) begin
        mon_rd = avl_read;
        #1;
        if (mon_rd) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", avl_readdata, 32'hDEAD_BEEF);
            end else begin
                check(name_q.pop_front(), avl_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        @(negedge sys_clk);
        avl_read    = 1'b1;
        avl_address = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge sys_clk);
        #1;
        avl_read = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        avl_write     = 1'b1;
        avl_address   = a;
        avl_writedata = d;
        @(posedge sys_clk);
        #1;
        avl_write = 1'b0;
    endtask

    task automatic xpt_report(input logic v, input logic [31:0] xy);
        @(negedge sys_clk);
        xpt_done  = 1'b1;
        xpt_valid = v;
        xpt_xy    = xy;
        @(posedge sys_clk);
        #1;
        xpt_done = 1'b0;
    endtask

    task automatic gt_report(input logic v, input logic [2:0] n);
        @(negedge sys_clk);
        gt_done  = 1'b1;
        gt_valid = v;
        gt_num   = n;
        @(posedge sys_clk);
        #1;
        gt_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst       = 1'b1;
        lcd_init_done = 1'b1;
        lcd_id        = 16'h9341;
        xpt_done      = 1'b0;
        xpt_valid     = 1'b0;
        xpt_xy        = '0;
        gt_done       = 1'b0;
        gt_valid      = 1'b0;
        gt_num        = 3'd0;
        gt_xy         = {P4, P3, P2, P1, P0};
        avl_address   = '0;
        avl_write     = 1'b0;
        avl_read      = 1'b0;
        avl_writedata = '0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check("reset_readdata", avl_readdata, 32'h0);
        repeat (3) @(posedge sys_clk);

        rd(4'd0,  32'h0000_0000, "reset_status");
        rd(4'd1,  32'h0000_0001, "reset_ctrl");
        rd(4'd15, 32'h0000_0000, "unmapped_addr");

        // Source A single point capture, then release by timeout.
        xpt_report(1'b1, 32'h0064_00C8);                 // capture edge E0
        rd(4'd0, 32'h0000_0119, "a_status_new");         // E1
        rd(4'd2, 32'h0064_00C8, "a_point0");             // E2
        rd(4'd0, 32'h0000_0109, "a_status_cleared");     // E3
        rd(4'd3, 32'h0000_0000, "a_point1");             // E4
        repeat (4) @(posedge sys_clk);                   // E5..E8
        rd(4'd0, 32'h0000_0109, "a_before_release_e9");  // E9
        rd(4'd0, 32'h0000_0109, "a_before_release_e10"); // E10: release lands here
        rd(4'd0, 32'h0000_0210, "a_after_release");      // E11
        rd(4'd2, 32'h0000_0000, "a_point0_released");
        rd(4'd0, 32'h0000_0200, "a_status_idle");

        // Switch to the capacitive source; gt_num=7 clamps to 5.
        @(negedge sys_clk);
        lcd_id = 16'h5510;
        repeat (3) @(posedge sys_clk);
        gt_report(1'b1, 3'd7);
        rd(4'd0, 32'h0000_031D, "b_status_clamp");
        rd(4'd2, P0, "b_point0");
        rd(4'd3, P1, "b_point1");
        rd(4'd4, P2, "b_point2");
        rd(4'd5, P3, "b_point3");
        rd(4'd6, P4, "b_point4");
        gt_report(1'b1, 3'd2);
        rd(4'd0, 32'h0000_041A, "b_status_num2");
        rd(4'd3, P1, "b2_point1");
        rd(4'd4, 32'h0, "b2_point2_zero");
        rd(4'd5, 32'h0, "b2_point3_zero");
        rd(4'd6, 32'h0, "b2_point4_zero");
        xpt_report(1'b0, 32'h1234_5678);                 // unselected source: ignored
        rd(4'd0, 32'h0000_040A, "b_unselected_ignored");

        // STATUS read in the same cycle as a capture.
        @(negedge sys_clk);
        gt_num      = 3'd3;
        gt_valid    = 1'b1;
        gt_done     = 1'b1;
        avl_read    = 1'b1;
        avl_address = 4'd0;
        exp_q.push_back(32'h0000_040A);
        name_q.push_back("status_during_capture");
        @(posedge sys_clk);
        #1;
        gt_done  = 1'b0;
        avl_read = 1'b0;
        rd(4'd4, 32'h0, "snap_precapture_point2");
        rd(4'd0, 32'h0000_051B, "status_postcapture");
        rd(4'd4, P2, "snap_postcapture_point2");

        // Release on a done pulse with valid=0.
        gt_report(1'b0, 3'd0);
        rd(4'd0, 32'h0000_0610, "release_by_invalid");

        // Clearing enable mid-touch.
        gt_report(1'b1, 3'd1);
        wr(4'd1, 32'h0);
        @(posedge sys_clk);
        rd(4'd0, 32'h0000_0710, "disable_clears_live");
        rd(4'd1, 32'h0000_0000, "ctrl_disabled");
        gt_report(1'b1, 3'd1);
        rd(4'd0, 32'h0000_0700, "disabled_ignores_capture");
        wr(4'd1, 32'h1);
        repeat (2) @(posedge sys_clk);

        // Sequence wrap: seq is 7 here, 249 more captures bring it to 0.
        for (int i = 0; i < 249; i++) gt_report(1'b1, 3'd1);
        rd(4'd0, 32'h0000_0019, "seq_wrap");

        // Asynchronous reset mid-ACTIVE.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("async_reset_readdata", avl_readdata, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        rd(4'd0, 32'h0000_0000, "post_reset_status");
        rd(4'd1, 32'h0000_0001, "post_reset_ctrl");
        rd(4'd2, 32'h0000_0000, "post_reset_point0");

        wr(4'd1, 32'h3);
`ifdef TOUCH_IRQ_EN
        rd(4'd1, 32'h0000_0003, "ctrl_irq_en");
        gt_report(1'b1, 3'd1);
        check("irq_set", {31'd0, irq}, 32'h1);
        rd(4'd0, 32'h0000_0119, "irq_status");
        check("irq_cleared", {31'd0, irq}, 32'h0);
`else
        rd(4'd1, 32'h0000_0001, "ctrl_irq_bit_ignored");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge sys_clk);
        #2;
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
